// File: rtl/pcie_mfx_tx_arb.sv
// Round-robin TLP transmit arbiter. It grants one channel at a time to the PCIe core TX port,
// and a channel is granted only when the core advertises enough header and data credits for its class.
module pcie_mfx_tx_arb #(
    parameter int NUM_CH      = 8,
    parameter int DW          = 16,
    parameter int LEN_W       = 10,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                    ix_clk_125,
    input  logic                    ix_rst,
    input  logic [NUM_CH-1:0]       ix_ch_req,
    input  logic [2*NUM_CH-1:0]     ix_ch_cls,
    input  logic [LEN_W*NUM_CH-1:0] ix_ch_len,
    input  logic [DW*NUM_CH-1:0]    ix_ch_dat,
    input  logic [NUM_CH-1:0]       ix_ch_end,
    output logic [NUM_CH-1:0]       ox_ch_gnt,
    output logic [NUM_CH-1:0]       ox_ch_rd,
    input  logic [8:0]              ix_ipx_tx_ca_ph,
    input  logic [12:0]             ix_ipx_tx_ca_pd,
    input  logic [8:0]              ix_ipx_tx_ca_nph,
    input  logic [12:0]             ix_ipx_tx_ca_npd,
    input  logic [8:0]              ix_ipx_tx_ca_cplh,
    input  logic [12:0]             ix_ipx_tx_ca_cpld,
    input  logic                    ix_ipx_tx_rdy,
    output logic                    ox_ipx_tx_req,
    output logic                    ox_ipx_tx_st,
    output logic                    ox_ipx_tx_end,
    output logic [DW-1:0]           ox_ipx_tx_data,
    output logic                    ox_timeout
);
    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);
    localparam int CMP_W = (LEN_W + 1 > 12) ? LEN_W + 1 : 12;

    typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   grant_reg, grant_next;
    logic [CW-1:0]   rr_reg, rr_next;
    logic [TW-1:0]   cnt_reg, cnt_next;
    logic            st_pend_reg, st_pend_next;
    logic            timeout_reg, timeout_next;

    logic [NUM_CH-1:0] eligible;
    logic [CW-1:0]     pick;
    logic              any_elig;
    logic [NUM_CH-1:0] gnt_onehot;
    logic [CW-1:0]     grant_inc;

    // Per-channel credit check; the header must have at least one credit, and the data
    // credits (4DW units) must cover the rounded-up payload length.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_elig
        logic [1:0]       cls;
        logic [LEN_W-1:0] len;
        logic [LEN_W:0]   dcred;
        logic [8:0]       hcr;
        logic [12:0]      dcr;
        logic             hdr_ok;
        logic             dat_ok;

        assign cls   = ix_ch_cls[2*gi +: 2];
        assign len   = ix_ch_len[LEN_W*gi +: LEN_W];
        assign dcred = ({1'b0, len} + (LEN_W+1)'(3)) >> 2;

        always_comb begin
            case (cls)
                2'b00:   begin hcr = ix_ipx_tx_ca_ph;   dcr = ix_ipx_tx_ca_pd;   end
                2'b01:   begin hcr = ix_ipx_tx_ca_nph;  dcr = ix_ipx_tx_ca_npd;  end
                default: begin hcr = ix_ipx_tx_ca_cplh; dcr = ix_ipx_tx_ca_cpld; end
            endcase
        end

        assign hdr_ok = hcr[8] | (hcr[7:0] != 8'd0);
        assign dat_ok = (len == '0) | dcr[12] | (CMP_W'(dcr[11:0]) >= CMP_W'(dcred));
        assign eligible[gi] = ix_ch_req[gi] & (cls != 2'b11) & hdr_ok & dat_ok;
    end

    // The scan runs from the farthest offset back to the nearest, so the nearest eligible channel is chosen.
    always_comb begin
        int idx;
        pick     = '0;
        any_elig = 1'b0;
        idx      = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = int'(rr_reg) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (eligible[idx]) begin
                pick     = CW'(idx);
                any_elig = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_onehot            = '0;
        gnt_onehot[grant_reg] = 1'b1;
    end

    assign grant_inc = (grant_reg == CW'(NUM_CH - 1)) ? '0 : grant_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        rr_next        = rr_reg;
        cnt_next       = cnt_reg;
        st_pend_next   = st_pend_reg;
        timeout_next   = 1'b0;
        ox_ch_gnt      = '0;
        ox_ch_rd       = '0;
        ox_ipx_tx_req  = 1'b0;
        ox_ipx_tx_st   = 1'b0;
        ox_ipx_tx_end  = 1'b0;
        ox_ipx_tx_data = '0;
        case (state_reg)
            IDLE: begin
                if (any_elig) begin
                    grant_next = pick;
                    cnt_next   = '0;
                    state_next = REQ;
                end
            end
            REQ: begin
                ox_ipx_tx_req = 1'b1;
                ox_ch_gnt     = gnt_onehot;
                if (ix_ipx_tx_rdy) begin
                    st_pend_next = 1'b1;
                    state_next   = XFER;
                end else if (cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
                    timeout_next = 1'b1;
                    rr_next      = grant_inc;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt_reg + TW'(1);
                end
            end
            XFER: begin
                ox_ch_gnt      = gnt_onehot;
                ox_ch_rd       = ix_ipx_tx_rdy ? gnt_onehot : '0;
                ox_ipx_tx_st   = st_pend_reg;
                ox_ipx_tx_end  = ix_ch_end[grant_reg];
                ox_ipx_tx_data = ix_ch_dat[grant_reg*DW +: DW];
                if (ix_ipx_tx_rdy) begin
                    st_pend_next = 1'b0;
                    if (ix_ch_end[grant_reg]) begin
                        rr_next    = grant_inc;
                        state_next = GAP;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ox_timeout = timeout_reg;

    always_ff @(posedge ix_clk_125 or posedge ix_rst) begin
        if (ix_rst) begin
            state_reg   <= IDLE;
            grant_reg   <= '0;
            rr_reg      <= '0;
            cnt_reg     <= '0;
            st_pend_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            rr_reg      <= rr_next;
            cnt_reg     <= cnt_next;
            st_pend_reg <= st_pend_next;
            timeout_reg <= timeout_next;
        end
    end
endmodule
